// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the MEM-stage memory bus (data memory plus peripheral/UART space,
// selected by address bit 30) between the CPU MEM stage and a DMA master.
// The CPU has priority; a starvation guard forces a DMA grant after MAX_WAIT
// refused cycles, and DMA bursts are capped at BURST_LEN words while the CPU
// is waiting. All outputs are combinational from state and inputs.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_cpu_rd/wr/addr/wdata  CPU MEM-stage access
//   o_cpu_rdata, o_cpu_stall read data to CPU, pipeline hold
//   i_dma_req/wr/addr/wdata DMA access
//   o_dma_gnt, o_dma_rdata  DMA serviced this cycle, read data to DMA
//   o_dma_err               DMA access to peripheral space rejected
//   o_mem_rd/wr/addr/wdata  slave bus strobes, address, write data
//   i_dm_rdata, i_per_rdata combinational slave read data
module mem_bus_arbiter #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned MAX_WAIT  = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cpu_rd,
    input  logic        i_cpu_wr,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_stall,
    input  logic        i_dma_req,
    input  logic        i_dma_wr,
    input  logic [31:0] i_dma_addr,
    input  logic [31:0] i_dma_wdata,
    output logic        o_dma_gnt,
    output logic [31:0] o_dma_rdata,
    output logic        o_dma_err,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_dm_rdata,
    input  logic [31:0] i_per_rdata
);

    localparam logic [3:0] BurstLen = 4'(BURST_LEN);
    localparam logic [7:0] MaxWait  = 8'(MAX_WAIT);

    typedef enum logic {
        OwnCpu = 1'b0,
        OwnDma = 1'b1
    } owner_e;

    owner_e      r_owner;
    logic [3:0]  r_burst_cnt;
    logic [7:0]  r_wait_cnt;

    logic        w_cpu_req;
    logic        w_dma_gnt;
    logic        w_cpu_served;
    logic        w_dma_err;
    logic [31:0] w_rdata_sel;

    // Grant decision
    always_comb begin
        w_cpu_req = i_cpu_rd | i_cpu_wr;
        if (r_owner == OwnCpu) begin
            w_dma_gnt = i_dma_req && (!w_cpu_req || (r_wait_cnt == MaxWait));
        end else begin
            w_dma_gnt = i_dma_req && (!w_cpu_req || (r_burst_cnt < BurstLen));
        end
        w_cpu_served = w_cpu_req && !w_dma_gnt;
        w_dma_err    = w_dma_gnt && i_dma_addr[30];
    end

    // Bus mux. A stalled CPU access never reaches the bus.
    always_comb begin
        o_mem_rd    = 1'b0;
        o_mem_wr    = 1'b0;
        o_mem_addr  = 32'h0;
        o_mem_wdata = 32'h0;
        if (w_dma_gnt) begin
            // Peripheral-space DMA keeps address/data on the bus but no strobe
            o_mem_rd    = !i_dma_wr && !w_dma_err;
            o_mem_wr    = i_dma_wr && !w_dma_err;
            o_mem_addr  = i_dma_addr;
            o_mem_wdata = i_dma_wdata;
        end else if (w_cpu_served) begin
            o_mem_rd    = i_cpu_rd;
            o_mem_wr    = i_cpu_wr;
            o_mem_addr  = i_cpu_addr;
            o_mem_wdata = i_cpu_wdata;
        end
    end

    // Read path and handshake outputs
    always_comb begin
        w_rdata_sel = o_mem_addr[30] ? i_per_rdata : i_dm_rdata;
        o_cpu_rdata = w_cpu_served ? w_rdata_sel : 32'h0;
        o_dma_rdata = w_dma_gnt ? w_rdata_sel : 32'h0;
        o_cpu_stall = w_dma_gnt && w_cpu_req;
        o_dma_gnt   = w_dma_gnt;
        o_dma_err   = w_dma_err;
    end

    // Ownership and counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner     <= OwnCpu;
            r_burst_cnt <= 4'd0;
            r_wait_cnt  <= 8'd0;
        end else begin
            if (w_dma_gnt) begin
                r_owner <= OwnDma;
                if (r_owner == OwnCpu) begin
                    r_burst_cnt <= 4'd1;
                end else if (r_burst_cnt != 4'hF) begin
                    r_burst_cnt <= r_burst_cnt + 4'd1;
                end
            end else begin
                // CPU takes the bus in the same cycle, no bubble
                r_owner     <= OwnCpu;
                r_burst_cnt <= 4'd0;
            end

            if (w_dma_gnt || !i_dma_req) begin
                r_wait_cnt <= 8'd0;
            end else if (r_wait_cnt < MaxWait) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration rules
// and a model of the slave memories.
module tb_mem_bus_arbiter;

    localparam int BL = 4;
    localparam int MW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_wr;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_gnt, dma_err;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] dm_rdata, per_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .BURST_LEN (BL),
        .MAX_WAIT  (MW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_cpu_rd    (cpu_rd),
        .i_cpu_wr    (cpu_wr),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_stall (cpu_stall),
        .i_dma_req   (dma_req),
        .i_dma_wr    (dma_wr),
        .i_dma_addr  (dma_addr),
        .i_dma_wdata (dma_wdata),
        .o_dma_gnt   (dma_gnt),
        .o_dma_rdata (dma_rdata),
        .o_dma_err   (dma_err),
        .o_mem_rd    (mem_rd),
        .o_mem_wr    (mem_wr),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_dm_rdata  (dm_rdata),
        .i_per_rdata (per_rdata)
    );

    // Slave memories driven by the DUT bus
    logic [31:0] dm  [64];
    logic [31:0] per [64];
    assign dm_rdata  = dm[mem_addr[7:2]];
    assign per_rdata = per[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wr) begin
            if (mem_addr[30]) per[mem_addr[7:2]] <= mem_wdata;
            else              dm[mem_addr[7:2]]  <= mem_wdata;
        end
    end

    // Reference model state
    logic [31:0] md [64];
    logic [31:0] mp [64];
    bit          m_dma_owner;
    int          m_burst;
    int          m_wait;
    bit          e_gnt;
    bit          s_gnt;
    bit          s_stall;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock cycle: inputs already driven after a falling edge.
    task automatic cycle(input bit en);
        bit          creq, g, srv, err, erd, ewr;
        logic [31:0] ea, ewd, rsel;
        #1;
        creq = cpu_rd || cpu_wr;
        if (!m_dma_owner) g = dma_req && (!creq || m_wait == MW);
        else              g = dma_req && (!creq || m_burst < BL);
        srv = creq && !g;
        err = g && dma_addr[30];
        erd = 0; ewr = 0; ea = 0; ewd = 0;
        if (g) begin
            erd = !dma_wr && !err; ewr = dma_wr && !err;
            ea = dma_addr; ewd = dma_wdata;
        end else if (srv) begin
            erd = cpu_rd; ewr = cpu_wr; ea = cpu_addr; ewd = cpu_wdata;
        end
        rsel = ea[30] ? mp[ea[7:2]] : md[ea[7:2]];
        e_gnt = g;
        if (en) begin
            chk("dma_gnt",   {31'b0, dma_gnt},   {31'b0, g});
            chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, g && creq});
            chk("dma_err",   {31'b0, dma_err},   {31'b0, err});
            chk("mem_rd",    {31'b0, mem_rd},    {31'b0, erd});
            chk("mem_wr",    {31'b0, mem_wr},    {31'b0, ewr});
            chk("mem_addr",  mem_addr,  ea);
            chk("mem_wdata", mem_wdata, ewd);
            chk("cpu_rdata", cpu_rdata, srv ? rsel : 32'h0);
            chk("dma_rdata", dma_rdata, g ? rsel : 32'h0);
        end
        s_gnt   = dma_gnt;
        s_stall = cpu_stall;
        if (ewr) begin
            if (ea[30]) mp[ea[7:2]] = ewd;
            else        md[ea[7:2]] = ewd;
        end
        if (reset) begin
            m_dma_owner = 0; m_burst = 0; m_wait = 0;
        end else begin
            if (g) begin
                m_burst = m_dma_owner ? ((m_burst < 15) ? m_burst + 1 : 15) : 1;
                m_dma_owner = 1;
            end else begin
                m_dma_owner = 0; m_burst = 0;
            end
            if (g || !dma_req) m_wait = 0;
            else if (m_wait < MW) m_wait++;
        end
        @(negedge clk);
    endtask

    task automatic cpu(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dma(input bit req, input bit wr, input logic [31:0] a, input logic [31:0] d);
        dma_req = req; dma_wr = wr; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        logic [9:0] gvec;
        logic [31:0] ra;
        int k;
        for (int i = 0; i < 64; i++) begin
            dm[i]  = 32'hA500_0000 | i;  md[i] = 32'hA500_0000 | i;
            per[i] = 32'h5A00_0000 | i;  mp[i] = 32'h5A00_0000 | i;
        end
        m_dma_owner = 0; m_burst = 0; m_wait = 0;
        reset = 1;
        cpu(0, 0, 0, 0);
        dma(0, 0, 0, 0);
        @(negedge clk);
        cycle(1);
        cycle(1);
        reset = 0;

        // CPU only: write then read back
        cpu(0, 1, 32'h10, 32'hDEAD_BEEF);
        cycle(1);
        chk("cpu_wr_nostall", {31'b0, s_stall}, 32'h0);
        cpu(1, 0, 32'h10, 32'h0);
        #1 chk("cpu_rd_back", cpu_rdata, 32'hDEAD_BEEF);
        cycle(1);
        cpu(0, 0, 0, 0);

        // DMA only: 6-word write burst, then CPU reads one back
        for (int i = 0; i < 6; i++) begin
            dma(1, 1, 32'h20 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            cycle(1);
            chk("dma_only_gnt", {31'b0, s_gnt}, 32'h1);
        end
        dma(0, 0, 0, 0);
        cpu(1, 0, 32'h2C, 0);
        #1 chk("dma_wr_mem", cpu_rdata, 32'hC0DE_0003);
        cycle(1);
        cpu(0, 0, 0, 0);
        cycle(1);

        // Contention: CPU raises read on burst word 2
        gvec = 0;
        for (int i = 0; i < 6; i++) begin
            dma(1, 1, 32'h80 + 32'(4 * i), 32'hB000_0000 + 32'(i));
            if (i >= 1) cpu(1, 0, 32'h10, 0);
            cycle(1);
            gvec[i] = s_gnt;
        end
        chk("burst_cap_seq", {22'b0, gvec}, 32'h0F);
        cpu(0, 0, 0, 0);
        dma(0, 0, 0, 0);
        cycle(1);

        // Starvation: CPU busy every cycle, DMA forced in after MW refusals
        gvec = 0;
        cpu(1, 0, 32'h10, 0);
        dma(1, 0, 32'h24, 0);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1);
            gvec[i] = s_gnt;
            if (s_gnt) k = i;
            if (e_gnt) dma(0, 0, 0, 0);
        end
        chk("starve_seq", {22'b0, gvec}, 32'h100);
        chk("starve_cycle", 32'(k), 32'(MW));
        cpu(0, 0, 0, 0);
        cycle(1);

        // Peripheral reject, then CPU reads peripheral register
        dma(1, 1, 32'h4000_0004, 32'h1234_5678);
        #1 chk("per_err", {30'b0, dma_err, mem_wr}, 32'h2);
        cycle(1);
        dma(0, 0, 0, 0);
        cpu(1, 0, 32'h4000_0004, 0);
        #1 chk("per_unchanged", cpu_rdata, 32'h5A00_0001);
        cycle(1);
        cpu(0, 0, 0, 0);

        // Reset mid-burst
        dma(1, 0, 32'h20, 0);
        cycle(1);
        dma(1, 0, 32'h24, 0);
        cycle(1);
        reset = 1;
        cycle(0);
        reset = 0;
        cpu(1, 0, 32'h10, 0);
        dma(1, 0, 32'h28, 0);
        #1 chk("post_reset_cpu_first", {30'b0, dma_gnt, cpu_stall}, 32'h0);
        cycle(1);
        cpu(0, 0, 0, 0);
        dma(0, 0, 0, 0);
        cycle(1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 3);
            ra = {1'b0, ($urandom_range(0, 7) == 0), 22'b0, 6'($urandom), 2'b0};
            cpu(k == 1, k == 2, ra, $urandom);
            ra = {1'b0, ($urandom_range(0, 7) == 0), 22'b0, 6'($urandom), 2'b0};
            dma($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, ra, $urandom);
            cycle(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
